// File: rtl/switch_control.sv
// ---------------------------------------------------------------------------
// switch_control
//
// Separable per-output allocator placed directly after route selection.
// Each cycle it takes one output request per input, grants every output port
// to at most one input, drives the crossbar one-hot selects and returns pop
// strobes to the input buffers. Each output arbitrates round-robin. An input
// that has waited STARVE_LIMIT consecutive cycles is marked starved, and
// starved inputs win ahead of the round-robin order.
//
// Ports
//   clk            : clock
//   reset_n        : asynchronous active-low reset
//   i_output_req   : [input][output] requests; bit m set = input wants output m
//   i_out_ready    : [output] downstream can accept a packet this cycle
//   o_output_grant : [output][input] one-hot winner per output, zero = idle
//   o_input_grant  : [input] input popped this cycle
//   o_starved      : [input] input's wait counter sits at STARVE_LIMIT
// ---------------------------------------------------------------------------
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

module switch_control #(
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [0:`N-1][0:`M-1] i_output_req,
    input  logic [0:`M-1]         i_out_ready,
    output logic [0:`M-1][0:`N-1] o_output_grant,
    output logic [0:`N-1]         o_input_grant,
    output logic [0:`N-1]         o_starved
);

    localparam int N  = `N;
    localparam int M  = `M;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [PW-1:0] LAST  = PW'(N - 1);

    logic [0:N-1][0:M-1] req_norm;   // requests reduced to their lowest output
    logic [0:M-1][0:N-1] grant;      // unmasked allocation result
    logic [0:N-1]        in_grant;
    logic [0:N-1]        starved;

    genvar gi;

    // -----------------------------------------------------------------------
    // Per-input logic: request normalisation and starvation counter
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < N; gi++) begin : g_in
            logic [0:M-1]  norm;
            logic          hit;
            logic [CW-1:0] wait_q;
            logic [CW-1:0] wait_d;

            // A multi-hot request is illegal upstream; keep only the lowest
            // output index so that every input competes for one output.
            always_comb begin
                norm = '0;
                hit  = 1'b0;
                for (int m = 0; m < M; m++) begin
                    if (i_output_req[gi][m] && !hit) begin
                        norm[m] = 1'b1;
                        hit     = 1'b1;
                    end
                end
            end

            assign req_norm[gi] = norm;

            // Every ungranted request cycle counts, including cycles lost to
            // a not-ready output.
            always_comb begin
                wait_d = '0;
                if ((i_output_req[gi] != '0) && !in_grant[gi]) begin
                    wait_d = (wait_q == LIMIT) ? LIMIT : wait_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wait_q <= '0;
                end else begin
                    wait_q <= wait_d;
                end
            end

            assign starved[gi] = (wait_q == LIMIT);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Per-output arbiter: round-robin from ptr_q, starved inputs first
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < M; gi++) begin : g_out
            logic [0:N-1]  elig;
            logic [0:N-1]  comp;
            logic [0:N-1]  win;
            logic [PW-1:0] win_idx;
            logic [PW:0]   idx;
            logic          found;
            logic [PW-1:0] ptr_q;
            logic [PW-1:0] ptr_d;

            always_comb begin
                elig    = '0;
                win     = '0;
                win_idx = '0;
                idx     = '0;
                found   = 1'b0;
                for (int i = 0; i < N; i++) begin
                    elig[i] = req_norm[i][gi] & i_out_ready[gi];
                end
                // Once any eligible input is starved, the rest sit out.
                comp = ((elig & starved) != '0) ? (elig & starved) : elig;
                // Scan ptr, ptr+1, ... modulo N; one extra bit avoids overflow.
                for (int k = 0; k < N; k++) begin
                    idx = {1'b0, ptr_q} + (PW+1)'(k);
                    if (idx >= (PW+1)'(N)) begin
                        idx = idx - (PW+1)'(N);
                    end
                    if (!found && comp[idx[PW-1:0]]) begin
                        found             = 1'b1;
                        win[idx[PW-1:0]]  = 1'b1;
                        win_idx           = idx[PW-1:0];
                    end
                end
            end

            assign grant[gi] = win;

            always_comb begin
                ptr_d = ptr_q;
                if (found) begin
                    ptr_d = (win_idx == LAST) ? '0 : win_idx + PW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end
    endgenerate

    // An input requests at most one output, so this OR never merges two wins.
    always_comb begin
        in_grant = '0;
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < M; m++) begin
                in_grant[i] = in_grant[i] | grant[m][i];
            end
        end
    end

    // Outputs drop to zero as soon as reset is asserted, without waiting for
    // the flops to clear.
    assign o_output_grant = reset_n ? grant    : '0;
    assign o_input_grant  = reset_n ? in_grant : '0;
    assign o_starved      = reset_n ? starved  : '0;

endmodule
